// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte path among NUM_REQ requesters.
// A grant is held for a whole packet; an optional header byte carries the requester ID.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int HDR_EN  = 1,
  parameter int TIMEOUT = 1024,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   send_enable,
  output logic [7:0]             byte_to_uart,
  input  logic                   byte_sent,
  output logic                   busy,
  output logic [ID_W-1:0]        grant_id,
  output logic                   timeout_err
);

  localparam int TMR_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  state_t             state_q;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [ID_W-1:0]    grant_q;
  logic               hdr_q;
  logic               last_q;
  logic               bsent_q;
  logic               send_q;
  logic               tout_q;
  logic [7:0]         byte_q;
  logic [NUM_REQ-1:0] ready_q;
  logic [TMR_W-1:0]   timer_q;

  logic               done;
  logic               found_d;
  logic [ID_W-1:0]    pick_d;
  logic [NUM_REQ-1:0] sel_oh;
  logic               cur_valid;
  logic               cur_last;
  logic [7:0]         cur_byte;

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id);
    if (int'(id) == NUM_REQ - 1) return '0;
    return id + 1'b1;
  endfunction

  function automatic logic [7:0] hdr_byte(input logic [ID_W-1:0] id);
    logic [3:0] id4;
    id4 = 4'(id);
    return {4'hA, id4};
  endfunction

  assign done = byte_sent & ~bsent_q;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin : rr_pick
    int idx;
    idx     = 0;
    pick_d  = rr_ptr_q;
    found_d = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found_d && req_valid[ID_W'(idx)]) begin
        found_d = 1'b1;
        pick_d  = ID_W'(idx);
      end
    end
  end

  always_comb begin
    sel_oh   = '0;
    cur_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == ID_W'(i)) begin
        sel_oh[i] = 1'b1;
        cur_byte  = req_data[8*i +: 8];
      end
    end
    cur_valid = |(req_valid & sel_oh);
    cur_last  = |(req_last & sel_oh);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      hdr_q    <= 1'b0;
      last_q   <= 1'b0;
      bsent_q  <= 1'b0;
      send_q   <= 1'b0;
      tout_q   <= 1'b0;
      byte_q   <= '0;
      ready_q  <= '0;
      timer_q  <= '0;
    end else begin
      bsent_q <= byte_sent;
      ready_q <= '0;
      tout_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (found_d) begin
            grant_q <= pick_d;
            hdr_q   <= (HDR_EN != 0);
            timer_q <= '0;
            if (HDR_EN != 0) begin
              byte_q  <= hdr_byte(pick_d);
              send_q  <= 1'b1;
              state_q <= SEND;
            end else begin
              state_q <= LOAD;
            end
          end
        end
        LOAD: begin
          if (cur_valid) begin
            byte_q  <= cur_byte;
            last_q  <= cur_last;
            ready_q <= sel_oh;
            send_q  <= 1'b1;
            timer_q <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          // send_enable drops right after the accept edge, so one byte is never sent twice.
          if (done) begin
            send_q  <= 1'b0;
            timer_q <= '0;
            if (hdr_q) begin
              hdr_q   <= 1'b0;
              state_q <= LOAD;
            end else if (last_q) begin
              rr_ptr_q <= wrap_inc(grant_q);
              state_q  <= IDLE;
            end else begin
              state_q <= LOAD;
            end
          end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
            tout_q   <= 1'b1;
            send_q   <= 1'b0;
            timer_q  <= '0;
            rr_ptr_q <= wrap_inc(grant_q);
            state_q  <= IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready    = ready_q;
  assign send_enable  = send_q;
  assign byte_to_uart = byte_q;
  assign busy         = (state_q != IDLE);
  assign grant_id     = grant_q;
  assign timeout_err  = tout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues feed the DUT, a downstream
// model accepts bytes and compares them against an expected-byte scoreboard.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [8*NR-1:0] req_data = '0;
  logic [NR-1:0]   req_last = '0;
  logic            byte_sent = 1'b0;
  logic [NR-1:0]   req_ready;
  logic            send_enable;
  logic [7:0]      byte_to_uart;
  logic            busy;
  logic [1:0]      grant_id;
  logic            timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .HDR_EN(1), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .send_enable(send_enable), .byte_to_uart(byte_to_uart),
    .byte_sent(byte_sent), .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
  );

  int         vectors = 0;
  int         miscompares = 0;
  logic [8:0] chq [NR][$];
  logic [7:0] exp_q [$];
  int         ready_cnt [NR];
  int         sent_cnt = 0;
  int         r2_at = -1;
  int         tout_total = 0;
  bit         ds_en = 1'b1;
  int         ds_cnt = 0;
  int         ds_hi = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_pkt(input int ch, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input int n);
    logic [7:0] b [3];
    b[0] = b0; b[1] = b1; b[2] = b2;
    exp_q.push_back({4'hA, 4'(ch)});
    for (int k = 0; k < n; k++) begin
      chq[ch].push_back({(k == n - 1), b[k]});
      exp_q.push_back(b[k]);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(exp_q.size() == 0 && busy == 1'b0) && n < 3000);
    check({tag, "_complete"}, (n < 3000), 1);
  endtask

  task automatic wait_send(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (send_enable !== 1'b1 && n < 100);
    check({tag, "_send_enable"}, send_enable, 1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_send_enable"}, send_enable, 0);
    check({tag, "_byte"}, byte_to_uart, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_grant"}, grant_id, 0);
    check({tag, "_timeout"}, timeout_err, 0);
    check({tag, "_ready"}, req_ready, 0);
  endtask

  task automatic clr_ready();
    for (int i = 0; i < NR; i++) ready_cnt[i] = 0;
  endtask

  // Requesters: present queue heads, pop on the consumed-byte pulse.
  initial forever begin
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (req_ready[i] && chq[i].size() > 0) void'(chq[i].pop_front());
      if (chq[i].size() > 0) begin
        req_valid[i]      = 1'b1;
        req_data[8*i +: 8] = chq[i][0][7:0];
        req_last[i]       = chq[i][0][8];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
  end

  // Downstream: byte_sent goes high 3 cycles after send_enable, for 2 cycles.
  initial forever begin
    @(negedge clk);
    if (ds_hi > 0) begin
      ds_hi--;
      if (ds_hi == 0) byte_sent = 1'b0;
    end else if (send_enable && ds_en) begin
      ds_cnt++;
      if (ds_cnt == 3) begin
        ds_cnt    = 0;
        ds_hi     = 2;
        byte_sent = 1'b1;
        sent_cnt++;
        if (exp_q.size() == 0) check("extra_byte", {24'd0, byte_to_uart}, 32'h100);
        else check("uart_byte", byte_to_uart, exp_q.pop_front());
      end
    end else begin
      ds_cnt = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (timeout_err === 1'b1) tout_total++;
    if (req_ready !== '0) begin
      check("ready_onehot", req_ready, 32'(1) << grant_id);
      for (int i = 0; i < NR; i++) if (req_ready[i]) ready_cnt[i]++;
      if (req_ready[2] && r2_at < 0) r2_at = sent_cnt;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end (vectors %0d)", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    clr_ready();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b1;

    // T1: single 3-byte packet from ch0
    send_pkt(0, 8'h11, 8'h22, 8'h33, 3);
    wait_idle("t1");
    check("t1_ready0", ready_cnt[0], 3);
    check("t1_busy", busy, 0);
    check("t1_grant_hold", grant_id, 0);

    // T2: simultaneous ch1/ch2 from rr_ptr=0, then again from rr_ptr=3
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    clr_ready();
    send_pkt(1, 8'h41, 8'h42, 8'h00, 2);
    send_pkt(2, 8'h51, 8'h52, 8'h00, 2);
    wait_idle("t2a");
    check("t2a_grant", grant_id, 2);
    send_pkt(1, 8'h43, 8'h44, 8'h00, 2);
    send_pkt(2, 8'h53, 8'h00, 8'h00, 1);
    wait_idle("t2b");
    check("t2b_grant", grant_id, 2);
    check("t2_ready1", ready_cnt[1], 4);
    check("t2_ready2", ready_cnt[2], 3);

    // T3: ch2 requests during ch0's packet
    clr_ready();
    sent_cnt = 0;
    r2_at = -1;
    send_pkt(0, 8'h11, 8'h22, 8'h33, 3);
    n = 0;
    while (ready_cnt[0] < 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t3_ch0_started", (ready_cnt[0] >= 1), 1);
    send_pkt(2, 8'h61, 8'h62, 8'h00, 2);
    wait_idle("t3");
    check("t3_first_ready2_after", r2_at, 5);
    check("t3_ready0", ready_cnt[0], 3);
    check("t3_ready2", ready_cnt[2], 2);

    // T4: downstream silent -> timeout, then the leftover bytes form a new packet
    ds_en = 1'b0;
    chq[3].push_back({1'b0, 8'h71});
    chq[3].push_back({1'b1, 8'h72});
    wait_send("t4");
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (timeout_err !== 1'b1 && n < 40);
    check("t4_latency", n, TO);
    check("t4_send_enable", send_enable, 0);
    check("t4_busy", busy, 0);
    check("t4_grant", grant_id, 3);
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h71);
    exp_q.push_back(8'h72);
    ds_en = 1'b1;
    @(negedge clk);
    check("t4_pulse_width", timeout_err, 0);
    wait_idle("t4");
    check("t4_timeouts", tout_total, 1);

    // T6: ch0 valid drops mid-packet; arbiter waits in LOAD without timing out
    clr_ready();
    chq[0].push_back({1'b0, 8'h81});
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'h81);
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6_first_byte", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (send_enable !== 1'b0 || timeout_err !== 1'b0 || busy !== 1'b1) bad++;
    end
    check("t6_hold_in_load", bad, 0);
    check("t6_grant", grant_id, 0);
    chq[0].push_back({1'b1, 8'h82});
    exp_q.push_back(8'h82);
    wait_idle("t6");
    check("t6_ready0", ready_cnt[0], 2);

    // T5: reset mid-SEND, then ch0 wins from rr_ptr=0
    ds_en = 1'b0;
    chq[1].push_back({1'b1, 8'h91});
    wait_send("t5");
    rst = 1'b0;
    @(negedge clk);
    check_reset("t5_reset");
    chq[1].delete();
    exp_q.delete();
    send_pkt(0, 8'hB1, 8'h00, 8'h00, 1);
    send_pkt(1, 8'hC1, 8'h00, 8'h00, 1);
    ds_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_idle("t5");
    check("t5_grant", grant_id, 1);
    check("total_timeouts", tout_total, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
